// File: rtl/hc_gate_bank.sv
// rtl/hc_gate_bank.sv - bank of synchronised, glitch-filtered, run-time selectable 2-input gates
module hc_gate_bank #(
    parameter int CH   = 4,
    parameter int FILT = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [CH:1]   A,
    input  logic [CH:1]   B,
    input  logic [1:0]    MODE,
    input  logic          OE,
    output logic [CH:1]   Y,
    output logic [CH:1]   CHG
);

    localparam int CW = $clog2(FILT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

    typedef enum logic [1:0] {
        GATE_AND  = 2'b00,
        GATE_OR   = 2'b01,
        GATE_XOR  = 2'b10,
        GATE_NAND = 2'b11
    } gate_mode_e;

    logic [CH:1]   a_s1_q, a_s2_q;
    logic [CH:1]   b_s1_q, b_s2_q;
    logic [CH:1]   acc_a_q, acc_a_d;
    logic [CH:1]   acc_b_q, acc_b_d;
    logic [CW-1:0] cnt_q [CH:1];
    logic [CW-1:0] cnt_d [CH:1];
    logic [CH:1]   y_q, y_d;
    logic [CH:1]   chg_q, chg_d;

    function automatic logic gate_fn(input logic [1:0] mode, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (gate_mode_e'(mode))
            GATE_AND:  r = a & b;
            GATE_OR:   r = a | b;
            GATE_XOR:  r = a ^ b;
            GATE_NAND: r = ~(a & b);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // The filter compares against the accepted pair, not the previous sample,
    // so a pair that wanders while pending keeps counting toward acceptance.
    always_comb begin
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        for (int i = 1; i <= CH; i++) begin
            cnt_d[i] = '0;
            if ((a_s2_q[i] != acc_a_q[i]) || (b_s2_q[i] != acc_b_q[i])) begin
                if (cnt_q[i] == CNT_LAST) begin
                    acc_a_d[i] = a_s2_q[i];
                    acc_b_d[i] = b_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        y_d = '0;
        for (int i = 1; i <= CH; i++) begin
            y_d[i] = OE ? gate_fn(MODE, acc_a_q[i], acc_b_q[i]) : 1'b0;
        end
        chg_d = y_d ^ y_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_s1_q  <= '0;
            a_s2_q  <= '0;
            b_s1_q  <= '0;
            b_s2_q  <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
            y_q     <= '0;
            chg_q   <= '0;
            for (int i = 1; i <= CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            a_s1_q  <= A;
            a_s2_q  <= a_s1_q;
            b_s1_q  <= B;
            b_s2_q  <= b_s1_q;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            y_q     <= y_d;
            chg_q   <= chg_d;
            for (int i = 1; i <= CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign Y   = y_q;
    assign CHG = chg_q;

endmodule

// File: tb/tb_hc_gate_bank.sv
// tb/tb_hc_gate_bank.sv - bench for hc_gate_bank: three parameter sets against one behavioural model
module tb_hc_gate_bank;

    logic       CLK;
    logic       RST;
    logic [8:1] A, B;
    logic [1:0] MODE;
    logic       OE;

    logic [4:1] y4, c4;
    logic [1:1] y1, c1;
    logic [8:1] y8, c8;

    int n_checks = 0;
    int n_fail   = 0;

    hc_gate_bank #(.CH(4), .FILT(2)) u_dut4 (
        .CLK(CLK), .RST(RST), .A(A[4:1]), .B(B[4:1]), .MODE(MODE), .OE(OE), .Y(y4), .CHG(c4)
    );
    hc_gate_bank #(.CH(1), .FILT(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .A(A[1:1]), .B(B[1:1]), .MODE(MODE), .OE(OE), .Y(y1), .CHG(c1)
    );
    hc_gate_bank #(.CH(8), .FILT(5)) u_dut8 (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .MODE(MODE), .OE(OE), .Y(y8), .CHG(c8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: inputs delayed two edges, a channel adopts a new pair
    // once it has differed from the adopted pair for FILT edges in a row.
    int         chn [3] = '{4, 1, 8};
    int         flt [3] = '{2, 1, 5};
    logic [8:1] ma1 [3], mb1 [3], ma2 [3], mb2 [3];
    logic [8:1] macc_a [3], macc_b [3], my [3], mchg [3];
    int         run [3][8];

    function automatic logic gate_ref(input logic [1:0] m, input logic a, input logic b);
        if (m == 2'd0) return a & b;
        if (m == 2'd1) return a | b;
        if (m == 2'd2) return a ^ b;
        return !(a && b);
    endfunction

    function automatic logic [8:1] mask_of(input int c);
        return (c >= 8) ? 8'hFF : 8'((1 << c) - 1);
    endfunction

    always @(posedge CLK or posedge RST) begin : model
        logic [8:1] ny;
        for (int k = 0; k < 3; k++) begin
            if (RST) begin
                ma1[k] = '0; mb1[k] = '0; ma2[k] = '0; mb2[k] = '0;
                macc_a[k] = '0; macc_b[k] = '0; my[k] = '0; mchg[k] = '0;
                for (int i = 0; i < 8; i++) run[k][i] = 0;
            end else begin
                ny = '0;
                for (int i = 1; i <= chn[k]; i++)
                    ny[i] = OE ? gate_ref(MODE, macc_a[k][i], macc_b[k][i]) : 1'b0;
                mchg[k] = ny ^ my[k];
                my[k]   = ny;
                for (int i = 1; i <= chn[k]; i++) begin
                    if (ma2[k][i] == macc_a[k][i] && mb2[k][i] == macc_b[k][i]) begin
                        run[k][i-1] = 0;
                    end else begin
                        run[k][i-1] = run[k][i-1] + 1;
                        if (run[k][i-1] >= flt[k]) begin
                            macc_a[k][i] = ma2[k][i];
                            macc_b[k][i] = mb2[k][i];
                            run[k][i-1]  = 0;
                        end
                    end
                end
                ma2[k] = ma1[k];
                mb2[k] = mb1[k];
                ma1[k] = A & mask_of(chn[k]);
                mb1[k] = B & mask_of(chn[k]);
            end
        end
    end

    logic [8:1] dy [3], dc [3];
    always_comb begin
        dy[0] = {4'b0, y4};  dc[0] = {4'b0, c4};
        dy[1] = {7'b0, y1};  dc[1] = {7'b0, c1};
        dy[2] = y8;          dc[2] = c8;
    end

    always @(posedge CLK) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dy[k] !== my[k] || dc[k] !== mchg[k]) begin
                n_fail++;
                $display("FAIL model_cmp inst%0d t=%0t: Y=%h CHG=%h expected Y=%h CHG=%h",
                         k, $time, dy[k], dc[k], my[k], mchg[k]);
            end
        end
    end

    task automatic pin(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] sweep [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};
    logic [3:0] prev;

    initial begin
        RST = 1'b1; A = 8'hFF; B = 8'hFF; MODE = 2'd0; OE = 1'b1;
        repeat (3) @(negedge CLK);
        pin("reset_y", 8'(y4), 8'h0);
        pin("reset_chg", 8'(c4), 8'h0);
        RST = 1'b0;
        repeat (4) edge_sample();
        pin("release_y_before", 8'(y4), 8'h0);
        edge_sample();
        pin("release_y", 8'(y4), 8'h0F);
        pin("release_chg", 8'(c4), 8'h0F);
        edge_sample();
        pin("release_chg_one_cycle", 8'(c4), 8'h0);

        // function sweep
        @(negedge CLK);
        A = 8'h0C; B = 8'h0A; MODE = 2'd0;
        repeat (10) @(negedge CLK);
        pin("sweep_and", 8'(y4), 8'(sweep[0]));
        prev = sweep[0];
        for (int m = 1; m < 4; m++) begin
            MODE = 2'(m);
            edge_sample();
            pin("sweep_y", 8'(y4), 8'(sweep[m]));
            pin("sweep_chg", 8'(c4), 8'(sweep[m] ^ prev));
            prev = sweep[m];
            @(negedge CLK);
        end

        // glitch rejection then acceptance on channel 2
        MODE = 2'd0; A = 8'hFF; B = 8'hFF;
        repeat (10) @(negedge CLK);
        A[2] = 1'b0;
        @(negedge CLK);
        A[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            edge_sample();
            pin("glitch_y", 8'(y4), 8'h0F);
            pin("glitch_chg", 8'(c4), 8'h0);
        end
        @(negedge CLK);
        A[2] = 1'b0;
        repeat (3) begin
            edge_sample();
            pin("hold_y_early", 8'(y4), 8'h0F);
        end
        @(negedge CLK);
        A[2] = 1'b1;
        edge_sample();
        pin("hold_y_early", 8'(y4), 8'h0F);
        edge_sample();
        pin("hold_y", 8'(y4), 8'h0D);
        pin("hold_chg", 8'(c4), 8'h02);

        // output enable
        @(negedge CLK);
        A = 8'h0C; B = 8'h0A; MODE = 2'd2;
        repeat (10) @(negedge CLK);
        pin("oe_steady", 8'(y4), 8'h06);
        OE = 1'b0;
        edge_sample();
        pin("oe_off_y", 8'(y4), 8'h0);
        pin("oe_off_chg", 8'(c4), 8'h06);
        repeat (5) @(negedge CLK);
        OE = 1'b1;
        edge_sample();
        pin("oe_on_y", 8'(y4), 8'h06);
        pin("oe_on_chg", 8'(c4), 8'h06);

        // reset during a pending change
        @(negedge CLK);
        MODE = 2'd0; A = 8'hFF; B = 8'hFF;
        repeat (10) @(negedge CLK);
        A[1] = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        pin("midrst_y", 8'(y4), 8'h0);
        pin("midrst_chg", 8'(c4), 8'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (4) edge_sample();
        pin("midrst_y_wait", 8'(y4), 8'h0);
        pin("midrst_chg_wait", 8'(c4), 8'h0);
        edge_sample();
        pin("midrst_y_accept", 8'(y4), 8'h0E);
        pin("midrst_chg_accept", 8'(c4), 8'h0E);

        // walking ones on the wide instance
        @(negedge CLK);
        MODE = 2'd0; B = 8'hFF;
        for (int j = 0; j < 8; j++) begin
            A = 8'(1) << j;
            repeat (12) @(negedge CLK);
            pin("walk_y8", y8, 8'(1) << j);
        end

        // four-cycle glitch on channel 8 of the FILT=5 instance
        A = 8'hFF;
        repeat (12) @(negedge CLK);
        A[8] = 1'b0;
        repeat (4) @(negedge CLK);
        A[8] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            edge_sample();
            pin("glitch5_y8", y8, 8'hFF);
        end

        // randomised soak
        @(negedge CLK);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) A = A ^ (8'(1) << $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) B = B ^ (8'(1) << $urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) MODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) OE = ~OE;
            if (RST) RST = 1'b0;
            else if ($urandom_range(0, 399) == 0) RST = 1'b1;
            @(negedge CLK);
        end

        RST = 1'b0;
        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
